// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//
// The operand is cut into STAGES segments of SEG = WIDTH/STAGES bits. Stage k adds
// segment k using GROUP-bit lookahead groups whose group carries are chained by
// c[j+1] = gg[j] | pg[j] & c[j]. The segment carry is registered and consumed by the
// next stage. Unconsumed high operand bits travel down the pipe with the data, and
// completed low sum bits are accumulated. As a result, each input is read exactly once.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     input handshake (in_ready never depends on in_valid)
//   a, b, cin, sub          operands; sub=1 computes a - b - cin
//   out_valid / out_ready   output handshake
//   s, cout, ovf, zero, neg result and flags, driven directly from the last stage

module cla_pipe #(
  parameter int WIDTH  = 64,
  parameter int GROUP  = 4,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / GROUP;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  b_eff;
  logic              c_first;

  // Subtraction is a + ~b + ~cin. A carry out of 1 therefore means no borrow occurred.
  assign b_eff   = sub ? ~b : b;
  assign c_first = cin ^ sub;

  // Bubble-collapsing load chain. A stage loads when it is empty or when its content
  // moves on. Evaluation runs from the output side back toward the input.
  always_comb begin
    logic nxt;
    ld  = '0;
    nxt = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = ~vld[k] | nxt;
      nxt   = ld[k];
    end
  end

  assign in_ready = ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = WIDTH - k * SEG;

    logic [IW-1:0]          op_a;
    logic [IW-1:0]          op_b;
    logic                   c_in;
    logic                   z_in;
    logic                   v_in;
    logic [SEG-1:0]         p;
    logic [SEG-1:0]         g;
    logic [SEG-1:0]         c;
    logic [SEG-1:0]         ssum;
    logic [NG-1:0]          pg;
    logic [NG-1:0]          gg;
    logic [NG:0]            cg;
    logic                   v_q;
    logic                   c_q;
    logic                   z_q;
    logic [(k+1)*SEG-1:0]   res_d;
    logic [(k+1)*SEG-1:0]   res_q;

    if (k == 0) begin : g_src
      assign op_a  = a;
      assign op_b  = b_eff;
      assign c_in  = c_first;
      assign z_in  = 1'b1;
      assign v_in  = in_valid;
      assign res_d = ssum;
    end else begin : g_src
      assign op_a  = g_stage[k-1].g_hi.a_q;
      assign op_b  = g_stage[k-1].g_hi.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign z_in  = g_stage[k-1].z_q;
      assign v_in  = g_stage[k-1].v_q;
      assign res_d = {ssum, g_stage[k-1].res_q};
    end

    assign p = op_a[SEG-1:0] ^ op_b[SEG-1:0];
    assign g = op_a[SEG-1:0] & op_b[SEG-1:0];

    // First level: group propagate/generate. Second level: group carries.
    // Bit carries inside each group then start from that group's carry-in.
    always_comb begin
      pg = '0;
      gg = '0;
      cg = '0;
      c  = '0;
      for (int j = 0; j < NG; j++) begin
        pg[j] = &p[j*GROUP +: GROUP];
        for (int i = 0; i < GROUP; i++) begin
          gg[j] = g[j*GROUP + i] | (p[j*GROUP + i] & gg[j]);
        end
      end
      cg[0] = c_in;
      for (int j = 0; j < NG; j++) begin
        cg[j+1] = gg[j] | (pg[j] & cg[j]);
      end
      for (int j = 0; j < NG; j++) begin
        c[j*GROUP] = cg[j];
        for (int i = 1; i < GROUP; i++) begin
          c[j*GROUP + i] = g[j*GROUP + i - 1] | (p[j*GROUP + i - 1] & c[j*GROUP + i - 1]);
        end
      end
    end

    assign ssum = p ^ c;

    // Data only updates on a valid load. A bubble passing through leaves the
    // previous values in place, so the outputs stay stable while out_valid is 0.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        z_q   <= 1'b0;
        res_q <= '0;
      end else if (ld[k]) begin
        v_q <= v_in;
        if (v_in) begin
          c_q   <= cg[NG];
          z_q   <= z_in & ~|ssum;
          res_q <= res_d;
        end
      end
    end

    assign vld[k] = v_q;

    if (k < STAGES - 1) begin : g_hi
      logic [IW-SEG-1:0] a_q;
      logic [IW-SEG-1:0] b_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[k] && v_in) begin
          a_q <= op_a[IW-1:SEG];
          b_q <= op_b[IW-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      // Carry into the MSB, used for signed overflow detection.
      logic cm_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cm_q <= 1'b0;
        end else if (ld[k] && v_in) begin
          cm_q <= c[SEG-1];
        end
      end

      assign out_valid = v_q;
      assign s         = res_q;
      assign cout      = c_q;
      assign ovf       = cm_q ^ c_q;
      assign zero      = z_q;
      assign neg       = res_q[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_cla_pipe.sv
// tb_cla_pipe: randomized and directed bench for cla_pipe, with a behavioural
// reference model and an in-order scoreboard.

module tb_cla_pipe;

  localparam int W   = 64;
  localparam int STG = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  res_t exp_q[$];

  cla_pipe #(.WIDTH(W), .GROUP(4), .STAGES(STG)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // The reference model works in wider arithmetic. A signed result fits in W bits
  // exactly when its top three bits (of W+2) agree.
  function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci, input logic sb);
    res_t r;
    logic [W:0]   ur;
    logic [W+1:0] sr;
    logic [W+1:0] sa;
    logic [W+1:0] sbx;
    logic [W+1:0] cx;
    sa  = {{2{aa[W-1]}}, aa};
    sbx = {{2{bb[W-1]}}, bb};
    cx  = {{(W+1){1'b0}}, ci};
    if (!sb) begin
      ur     = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci};
      r.s    = ur[W-1:0];
      r.cout = ur[W];
      sr     = sa + sbx + cx;
    end else begin
      r.s    = aa - bb - {{(W-1){1'b0}}, ci};
      r.cout = ({1'b0, aa} >= ({1'b0, bb} + {{W{1'b0}}, ci}));
      sr     = sa - sbx - cx;
    end
    r.ovf  = !((sr[W+1] == sr[W]) && (sr[W] == sr[W-1]));
    r.zero = (r.s == '0);
    r.neg  = r.s[W-1];
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.s = s; r.cout = cout; r.ovf = ovf; r.zero = zero; r.neg = neg;
    return r;
  endfunction

  task automatic chk_int(input string nm, input int got, input int ex);
    checks++;
    if (got != ex) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, ex);
    end
  endtask

  task automatic chk_res(input string nm, input res_t got, input res_t ex);
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s got s=%h c=%b o=%b z=%b n=%b expected s=%h c=%b o=%b z=%b n=%b",
               nm, got.s, got.cout, got.ovf, got.zero, got.neg,
               ex.s, ex.cout, ex.ovf, ex.zero, ex.neg);
    end
  endtask

  // Compare process: every output transfer pops the scoreboard, and a stall must
  // hold both out_valid and the result unchanged.
  logic stall_prev = 1'b0;
  res_t held;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk_int("stall_valid_hold", int'(out_valid), 1);
        chk_res("stall_data_hold", dut_res(), held);
      end
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_result got s=%h expected no result", s);
        end else begin
          chk_res("scoreboard", dut_res(), exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      stall_prev = out_valid && !out_ready;
      held = dut_res();
    end
  end

  task automatic drive_rand(input logic v);
    in_valid = v;
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: a = '1;
      1: b = '0;
      2: b = a;
      3: a = {1'b0, {(W-1){1'b1}}};
      4: b = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
  endtask

  task automatic single_op(input string nm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic ci, input logic sb, input res_t ex);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; a = aa; b = bb; cin = ci; sub = sb; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk_int({nm, "_latency"}, n, STG);
    chk_res(nm, dut_res(), ex);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk_int({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int acc;
    int p0;
    int sent;
    logic [W-1:0] s_snap;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_res("reset_outputs", dut_res(), '0);
    chk_int("reset_out_valid", int'(out_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_int("in_ready_after_reset", int'(in_ready), 1);

    // Directed wrap and overflow cases with hand-computed results
    single_op("wrap_add", '1, 64'd1, 1'b0, 1'b0, '{s: '0, cout: 1'b1, ovf: 1'b0, zero: 1'b1, neg: 1'b0});
    single_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
              '{s: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0, neg: 1'b1});
    single_op("sub_borrow", 64'd0, 64'd1, 1'b0, 1'b1, '{s: '1, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b1});
    single_op("sub_cin", 64'd10, 64'd3, 1'b1, 1'b1,
              '{s: 64'd6, cout: 1'b1, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
    drain("directed");

    // Back-to-back: 100 ops in consecutive cycles, one result per cycle
    p0  = pops;
    acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_rand(1'b1);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (STG) @(posedge clk);
    #1;
    chk_int("b2b_accepted", acc, 100);
    chk_int("b2b_results", pops - p0, 100);
    chk_int("b2b_empty_after", int'(out_valid), 0);

    // Fill with out_ready low: exactly STG accepted, then in_ready low and s stable
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1);
      @(negedge clk);
      if (in_ready) acc++;
      if (i == 5) s_snap = s;
      @(posedge clk); #1;
    end
    chk_int("fill_accepted", acc, STG);
    chk_int("fill_in_ready", int'(in_ready), 0);
    checks++;
    if (s !== s_snap) begin
      errors++;
      $display("FAIL fill_s_stable got=%h expected=%h", s, s_snap);
    end
    // Same cycle out_ready rises, a new input must be accepted
    out_ready = 1'b1;
    drive_rand(1'b1);
    @(negedge clk);
    chk_int("release_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    drain("fill_release");

    // Random valid/ready toggling over 1000 ops
    sent = 0;
    p0 = pops;
    while (sent < 1000) begin
      drive_rand(1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    drain("random");
    chk_int("random_count", pops - p0, 1000);

    // Reset with ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_int("inflight_out_valid", int'(out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_int("midreset_out_valid", int'(out_valid), 0);
    chk_res("midreset_outputs", dut_res(), '0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_int("post_reset_in_ready", int'(in_ready), 1);
    p0 = pops;
    single_op("after_reset", 64'd5, 64'd3, 1'b0, 1'b0,
              '{s: 64'd8, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
    drain("after_reset");
    chk_int("after_reset_count", pops - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
